regfile_writeback_queue: RTL and testbench

REGFILE_WRITEBACK_QUEUE -- requirements
Module: regfile_writeback_queue

---
 rtl/regfile_writeback_queue.sv | 144 ++++++++++++++
 tb/tb_regfile_writeback_queue.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback_queue.sv
// Writeback queue in front of the register-file write port.
// Holds pending writes in a FIFO and forwards the newest pending value.
module regfile_writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ADDR_W-1:0]         in_reg,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      port_busy,
  input  logic                      flush,
  output logic                      writeenable,
  output logic [ADDR_W-1:0]         writeregister,
  output logic [DATA_W-1:0]         writedata,
  input  logic [ADDR_W-1:0]         query1,
  input  logic [ADDR_W-1:0]         query2,
  output logic                      hit1,
  output logic                      hit2,
  output logic [DATA_W-1:0]         fwd1,
  output logic [DATA_W-1:0]         fwd2,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] r_reg  [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic              r_we;
  logic [ADDR_W-1:0] r_wreg;
  logic [DATA_W-1:0] r_wdata;

  logic              w_ready;
  logic              w_push;
  logic              w_pop;
  logic [PW-1:0]     w_idx [DEPTH];
  logic [DEPTH-1:0]  w_vld;
  logic              w_hit1;
  logic              w_hit2;
  logic [DATA_W-1:0] w_fwd1;
  logic [DATA_W-1:0] w_fwd2;

  assign w_ready = (r_count != CW'(DEPTH));
  // Writes to x0 are accepted but never stored.
  assign w_push  = in_valid & w_ready
                 & (in_reg != '0) & ~flush;
  assign w_pop   = (r_count != '0)
                 & ~port_busy & ~flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_we    <= 1'b0;
      r_wreg  <= '0;
      r_wdata <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_we    <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr  <= r_rptr + 1'b1;
        r_we    <= 1'b1;
        r_wreg  <= r_reg[r_rptr];
        r_wdata <= r_data[r_rptr];
      end else begin
        r_we    <= 1'b0;
      end
      r_count <= r_count + CW'(w_push)
                         - CW'(w_pop);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_reg[i]  <= '0;
        r_data[i] <= '0;
      end
    end else if (w_push) begin
      r_reg[r_wptr]  <= in_reg;
      r_data[r_wptr] <= in_data;
    end
  end

  // Walk oldest to youngest so the youngest match wins.
  always_comb begin
    w_hit1 = r_we & (r_wreg == query1);
    w_hit2 = r_we & (r_wreg == query2);
    w_fwd1 = r_wdata;
    w_fwd2 = r_wdata;
    w_vld  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx[k] = r_rptr + PW'(k);
      w_vld[k] = (CW'(k) < r_count);
      if (w_vld[k]) begin
        if (r_reg[w_idx[k]] == query1) begin
          w_hit1 = 1'b1;
          w_fwd1 = r_data[w_idx[k]];
        end
        if (r_reg[w_idx[k]] == query2) begin
          w_hit2 = 1'b1;
          w_fwd2 = r_data[w_idx[k]];
        end
      end
    end
    if (query1 == '0) begin
      w_hit1 = 1'b0;
    end
    if (query2 == '0) begin
      w_hit2 = 1'b0;
    end
    if (!w_hit1) begin
      w_fwd1 = '0;
    end
    if (!w_hit2) begin
      w_fwd2 = '0;
    end
  end

  assign in_ready      = w_ready;
  assign writeenable   = r_we;
  assign writeregister = r_wreg;
  assign writedata     = r_wdata;
  assign count         = r_count;
  assign hit1          = w_hit1;
  assign hit2          = w_hit2;
  assign fwd1          = w_fwd1;
  assign fwd2          = w_fwd2;

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Bench for regfile_writeback_queue: queue-level model checked every
// cycle plus directed scenarios with literal expectations.
module tb_regfile_writeback_queue;

  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int AW    = 5;

  logic          clk = 0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_reg;
  logic [DW-1:0] in_data;
  logic          port_busy;
  logic          flush;
  logic          writeenable;
  logic [AW-1:0] writeregister;
  logic [DW-1:0] writedata;
  logic [AW-1:0] query1;
  logic [AW-1:0] query2;
  logic          hit1;
  logic          hit2;
  logic [DW-1:0] fwd1;
  logic [DW-1:0] fwd2;
  logic [2:0]    count;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_writeback_queue #(
    .DEPTH(DEPTH), .DATA_W(DW), .ADDR_W(AW)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_reg(in_reg), .in_data(in_data),
    .port_busy(port_busy), .flush(flush),
    .writeenable(writeenable),
    .writeregister(writeregister),
    .writedata(writedata),
    .query1(query1), .query2(query2),
    .hit1(hit1), .hit2(hit2),
    .fwd1(fwd1), .fwd2(fwd2),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // Model: a plain queue of pending writes plus the output stage.
  typedef struct {
    logic [AW-1:0] r;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          mq[$];
  bit            m_we;
  logic [AW-1:0] m_wreg;
  logic [DW-1:0] m_wdata;
  bit            m_acc;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_we    = 0;
      m_wreg  = 0;
      m_wdata = 0;
    end else if (flush) begin
      mq.delete();
      m_we = 0;
    end else begin
      m_acc = in_valid && (mq.size() < DEPTH)
              && (in_reg != 0);
      if (mq.size() > 0 && !port_busy) begin
        m_we    = 1;
        m_wreg  = mq[0].r;
        m_wdata = mq[0].d;
        void'(mq.pop_front());
      end else begin
        m_we = 0;
      end
      if (m_acc) mq.push_back('{in_reg, in_data});
    end
  end

  function automatic void mlook(input logic [AW-1:0] q,
                                output bit h,
                                output logic [DW-1:0] f);
    h = 0;
    f = 0;
    if (q == 0) return;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (mq[i].r == q) begin
        h = 1;
        f = mq[i].d;
        return;
      end
    end
    if (m_we && m_wreg == q) begin
      h = 1;
      f = m_wdata;
    end
  endfunction

  bit            e_h1, e_h2;
  logic [DW-1:0] e_f1, e_f2;

  always @(negedge clk) begin
    chk("we", writeenable, m_we);
    chk("wreg", writeregister, m_wreg);
    chk("wdata", writedata, m_wdata);
    chk("count", count, mq.size());
    chk("in_ready", in_ready, mq.size() != DEPTH);
    mlook(query1, e_h1, e_f1);
    mlook(query2, e_h2, e_f2);
    chk("hit1", hit1, e_h1);
    chk("fwd1", fwd1, e_f1);
    chk("hit2", hit2, e_h2);
    chk("fwd2", fwd2, e_f2);
  end

  // Write log for the ordering scenario.
  bit            rec = 0;
  logic [DW-1:0] wlog[$];
  int            maxc = 0;

  always @(negedge clk) begin
    if (rec) begin
      if (writeenable) wlog.push_back(writedata);
      if (int'(count) > maxc) maxc = int'(count);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset     = 1;
    in_valid  = 0;
    in_reg    = 0;
    in_data   = 0;
    port_busy = 0;
    flush     = 0;
    query1    = 0;
    query2    = 0;
    #1 reset = 0;
    #2;
    chk("rst_count", count, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_we", writeenable, 0);
    step();
    step();
    reset = 1;
    step();

    // Single write latency
    in_valid = 1;
    in_reg   = 3;
    in_data  = 32'hDEADBEEF;
    step();
    in_valid = 0;
    step();
    chk("single_we", writeenable, 1);
    chk("single_reg", writeregister, 3);
    chk("single_data", writedata, 32'hDEADBEEF);
    step();
    chk("single_we_off", writeenable, 0);

    // Fill and back-pressure
    port_busy = 1;
    in_valid  = 1;
    for (int i = 1; i <= 4; i++) begin
      in_reg  = AW'(i);
      in_data = 32'h100 + 32'(i);
      step();
    end
    chk("full_count", count, 4);
    chk("full_ready", in_ready, 0);
    in_reg  = 5;
    in_data = 32'h105;
    step();
    chk("full_count5", count, 4);
    in_valid  = 0;
    port_busy = 0;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("drain_we", writeenable, 1);
      chk("drain_reg", writeregister, i);
      chk("drain_data", writedata, 32'h100 + 32'(i));
    end
    step();
    chk("drain_done", writeenable, 0);

    // Forwarding priority
    port_busy = 1;
    in_valid  = 1;
    in_reg    = 5;
    in_data   = 32'h11;
    step();
    in_data = 32'h22;
    step();
    in_valid = 0;
    query1   = 5;
    query2   = 6;
    #1;
    chk("fwd_hit1", hit1, 1);
    chk("fwd_val1", fwd1, 32'h22);
    chk("fwd_hit2", hit2, 0);
    chk("fwd_val2", fwd2, 0);
    port_busy = 0;
    step();
    chk("fwd_young", fwd1, 32'h22);
    step();
    chk("fwd_ostage_hit", hit1, 1);
    chk("fwd_ostage", fwd1, 32'h22);
    step();
    chk("fwd_gone", hit1, 0);

    // Zero register
    in_valid = 1;
    in_reg   = 0;
    in_data  = 32'hFFFF;
    query1   = 0;
    #1;
    chk("zero_hit", hit1, 0);
    step();
    in_valid = 0;
    chk("zero_count", count, 0);
    step();
    chk("zero_we", writeenable, 0);

    // Flush with same-cycle push
    port_busy = 1;
    in_valid  = 1;
    for (int i = 7; i <= 9; i++) begin
      in_reg  = AW'(i);
      in_data = 32'h70 + 32'(i);
      step();
    end
    chk("pre_flush", count, 3);
    flush   = 1;
    in_reg  = 10;
    in_data = 32'hAA;
    step();
    flush    = 0;
    in_valid = 0;
    chk("flush_count", count, 0);
    chk("flush_we", writeenable, 0);
    port_busy = 0;
    step();
    chk("flush_drop", writeenable, 0);

    // Asynchronous reset mid-drain
    port_busy = 1;
    in_valid  = 1;
    for (int i = 11; i <= 13; i++) begin
      in_reg  = AW'(i);
      in_data = 32'hB0 + 32'(i);
      step();
    end
    in_valid  = 0;
    port_busy = 0;
    step();
    chk("pre_rst_we", writeenable, 1);
    chk("pre_rst_reg", writeregister, 11);
    query1 = 12;
    #1 reset = 0;
    #1;
    chk("arst_we", writeenable, 0);
    chk("arst_reg", writeregister, 0);
    chk("arst_data", writedata, 0);
    chk("arst_count", count, 0);
    chk("arst_ready", in_ready, 1);
    chk("arst_hit", hit1, 0);
    chk("arst_fwd", fwd1, 0);
    step();
    step();
    reset = 1;
    step();
    chk("post_rst_we", writeenable, 0);
    in_valid = 1;
    in_reg   = 20;
    in_data  = 32'hC0FFEE;
    step();
    in_valid = 0;
    step();
    chk("post_rst_wr", writeenable, 1);
    chk("post_rst_reg", writeregister, 20);
    chk("post_rst_data", writedata, 32'hC0FFEE);
    step();

    // Ten push/pop pairs across pointer wrap
    rec = 1;
    in_valid = 1;
    for (int i = 0; i < 10; i++) begin
      in_reg  = AW'(i + 1);
      in_data = 32'hA000 + 32'(i);
      step();
    end
    in_valid = 0;
    step();
    step();
    step();
    rec = 0;
    chk("wrap_n", wlog.size(), 10);
    for (int i = 0; i < 10 && i < wlog.size(); i++)
      chk("wrap_order", wlog[i], 32'hA000 + 32'(i));
    chk("wrap_max", maxc <= DEPTH, 1);

    // Mixed traffic with intermittent stalls and a flush
    for (int i = 1; i <= 24; i++) begin
      in_valid  = 1;
      in_reg    = AW'((i * 3) % 32);
      in_data   = 32'(i) * 32'h1111;
      port_busy = (i % 3 == 0) || (i > 14 && i < 19);
      query1    = AW'((i * 3 + 29) % 32);
      query2    = AW'(i % 8);
      flush     = (i == 20);
      step();
    end
    in_valid  = 0;
    flush     = 0;
    port_busy = 0;
    for (int i = 0; i < 6; i++) step();

    $display("TB_RESULT checks=%0d failures=%0d",
             n_checks, n_fail);
    $finish;
  end

endmodule
